// File: rtl/configf_arbiter_if.sv
// Bundle of requester-side and host-side command signals around configf_arbiter.
// slave = arbiter view, master = requesters/host view.
interface configf_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_cmd_en_in;
    logic [NUM_REQ*8-1:0]  req_addr_in;
    logic [NUM_REQ*16-1:0] req_wrrd_num_in;
    logic [NUM_REQ-1:0]    req_cmd_done_out;
    logic                  req_timeout_out;
    logic                  arb_cmd_en_out;
    logic [7:0]            arb_addr_out;
    logic [15:0]           arb_wrrd_num_out;
    logic                  arb_cmd_done_in;
    logic                  arb_busy_out;
    logic [NUM_REQ-1:0]    arb_grant_out;

    modport slave (
        input  req_cmd_en_in, req_addr_in, req_wrrd_num_in, arb_cmd_done_in,
        output req_cmd_done_out, req_timeout_out, arb_cmd_en_out,
               arb_addr_out, arb_wrrd_num_out, arb_busy_out, arb_grant_out
    );

    modport master (
        output req_cmd_en_in, req_addr_in, req_wrrd_num_in, arb_cmd_done_in,
        input  req_cmd_done_out, req_timeout_out, arb_cmd_en_out,
               arb_addr_out, arb_wrrd_num_out, arb_busy_out, arb_grant_out
    );
endinterface

// File: rtl/configf_arbiter.sv
// Round-robin arbiter sharing the single configf host command port between NUM_REQ requesters.
// One command in flight; done is routed back to its owner, and a lost done is aborted by a watchdog.
module configf_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    configf_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned NUM_W  = 16;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX   = {WDOG_W{1'b1}};
    localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                cmd_en_q, cmd_en_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    pick_idx;

    // Scan last+NUM_REQ down to last+1 so the lowest offset that is requesting wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] sel;
        logic [31:0]      cand;
        sel = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(last) + 32'(k)) % NUM_REQ;
            if (req[IDX_W'(cand)]) begin
                sel = IDX_W'(cand);
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        addr_d    = addr_q;
        num_d     = num_q;
        grant_d   = grant_q;
        done_d    = '0;
        cmd_en_d  = 1'b0;
        timeout_d = 1'b0;
        pick_idx  = rr_pick(bus.req_cmd_en_in, last_q);

        case (state_q)
            S_IDLE: begin
                if (|bus.req_cmd_en_in) begin
                    cur_d    = pick_idx;
                    addr_d   = bus.req_addr_in[ADDR_W*32'(pick_idx) +: ADDR_W];
                    num_d    = bus.req_wrrd_num_in[NUM_W*32'(pick_idx) +: NUM_W];
                    grant_d  = NUM_REQ'(1) << pick_idx;
                    cmd_en_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real done beats a watchdog expiry in the same cycle.
                if (bus.arb_cmd_done_in) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
                    if (wdog_q == WDOG_LIMIT) begin
                        done_d    = grant_q;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                last_d  = cur_q;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            last_q    <= LAST_RST;
            wdog_q    <= '0;
            addr_q    <= '0;
            num_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            cmd_en_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            cmd_en_q  <= cmd_en_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_cmd_done_out = done_q;
    assign bus.req_timeout_out  = timeout_q;
    assign bus.arb_cmd_en_out   = cmd_en_q;
    assign bus.arb_addr_out     = addr_q;
    assign bus.arb_wrrd_num_out = num_q;
    assign bus.arb_busy_out     = busy_q;
    assign bus.arb_grant_out    = grant_q;
endmodule
